lc_token_cmp_seq: RTL
=====================

LC_TOKEN_CMP_SEQ -- requirements
Module: lc_token_cmp_seq

Interface
REQ-001 SHALL have parameter NumTokens, default 6, number of hashed token constants in the mux.
REQ-002 SHALL have parameter TokenWidth, default 128, width of one hashed token in bits.
REQ-003 SHALL have parameter ChunkWidth, default 32, bits compared per cycle; 1 <= ChunkWidth <= TokenWidth.
REQ-004 SHALL have parameter NumChecks, default 2, number of redundant full comparison passes; 1..4.
REQ-005 One clock; reset is synchronous and active-low: clk_i  in  1  block clock.
REQ-006 rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i.
REQ-007 req_i  in  1  start request, level; accepted only in Idle.
REQ-008 token_idx_i  in  vbits(NumTokens)  selects the expected constant; sampled at accept.
REQ-009 hashed_token_i  in  TokenWidth  computed hash of the user token; sampled at accept.
REQ-010 token_mux_i  in  NumTokens*TokenWidth  concatenated hashed constants, index 0 at LSBs; sampled at accept.
REQ-011 ack_o  out  1  single-cycle completion pulse.
REQ-012 match_o  out  lc_tx_t  On only if every pass matched; otherwise Off; held until the next accept.
REQ-013 busy_o  out  1  high from the accept cycle until ack_o, inclusive.
REQ-014 fsm_err_o  out  1  high while in the terminal Error state.

Function
REQ-015 Clocking: NumChunks = ceil(TokenWidth/ChunkWidth); the final chunk zero-pads both operands above TokenWidth.
REQ-016 States SHALL be Idle, Compare, Done, Error, using a sparse encoding with minimum Hamming distance >= 3.
REQ-017 Idle: req_i=1 latches all three data inputs, clears chunk and pass counters, goes to Compare; busy_o rises in the same cycle.
REQ-018 Compare: each cycle compares one latched chunk (chunk counter 0..NumChunks-1, LSB first) and ANDs the result into the pass-match flag.
REQ-019 At the chunk wrap, the pass-match flag SHALL be ANDed into the overall-match flag, the chunk counter SHALL return to 0, and the pass counter SHALL increment; after pass NumChecks-1 the FSM goes to Done.
REQ-020 Comparison time SHALL be constant: a mismatch does not end a pass early and does not skip the remaining passes.
REQ-021 Done: the FSM SHALL pulse ack_o for one cycle, drive match_o from the overall-match flag, drop busy_o in the next cycle, and return to Idle.
REQ-022 Latency: ack_o SHALL assert exactly NumChecks*NumChunks+1 cycles after the accept edge.
REQ-023 token_idx_i >= NumTokens SHALL force a mismatch; the full pass sequence still runs.
REQ-024 An all-zero selected constant SHALL force a mismatch (invalid-edge blocker).
REQ-025 req_i while busy SHALL be ignored; changes to the inputs after accept SHALL have no effect.
REQ-026 req_i held high in Done SHALL start a new accept on the cycle the FSM is back in Idle.
REQ-027 An invalid state encoding or a counter out of range SHALL enter Error, which is terminal until reset: fsm_err_o=1, match_o=Off, busy_o=1, ack_o=0.
REQ-028 match_o SHALL be driven only through lc_tx_bool_to_lc_tx; no other value is legal.

Reset
REQ-029 On rst_ni=0 at a clock edge: state=Idle, counters=0, flags=0, ack_o=0, busy_o=0, fsm_err_o=0, match_o=Off.
REQ-030 Reset during Compare SHALL abort the operation with no ack_o and no match_o=On glitch.
REQ-031 Reset SHALL clear Error.

Structure
REQ-032 The state enum and its encoding SHALL live in lc_ctrl_pkg next to fsm_state_e, together with function lc_token_num_chunks(TokenWidth, ChunkWidth).
REQ-033 lc_tx_t, On and Off SHALL be reused from lc_ctrl_pkg; no local copies.
REQ-034 The chunk selector and comparator SHALL form one sub-module, lc_token_chunk_cmp (combinational, parametrised by ChunkWidth).
REQ-035 Static assertions SHALL check ChunkWidth <= TokenWidth, NumChecks in 1..4, and NumTokens >= 2.

Verification
REQ-036 Defaults, idx=2, hash equal to constant 2 -> ack_o at cycle 9 after accept, match_o=On.
REQ-037 Defaults, hash differing only in bit 127 -> ack_o at cycle 9, match_o=Off.
REQ-038 TokenWidth=40, ChunkWidth=16, NumChecks=1, equal operands -> 3 chunks, ack_o at cycle 4, match_o=On.
REQ-039 idx=7 (>= NumTokens), and separately idx=5 with constant 5 = 0 and hash = 0 -> ack_o at cycle 9, match_o=Off.
REQ-040 req_i re-pulsed and hashed_token_i changed at cycle 3 -> no restart, result from the latched data, busy_o=1 throughout.
REQ-041 Force illegal state bits at cycle 4 -> fsm_err_o=1 and match_o=Off persist until rst_ni=0; rst_ni=0 at cycle 5 of a run -> Idle next cycle, no ack_o.

Source files
------------

// File: rtl/lc_ctrl_pkg.sv
// Life-cycle controller shared types: multi-bit lc_tx_t booleans, the main
// LC FSM encoding and the token comparison sequencer encoding.
package lc_ctrl_pkg;

    // Multi-bit boolean: only On and Off are legal values.
    typedef enum logic [3:0] {
        On  = 4'b0101,
        Off = 4'b1010
    } lc_tx_t;

    // Main life-cycle FSM encoding.
    typedef enum logic [5:0] {
        ResetSt     = 6'b001010,
        IdleSt      = 6'b110001,
        ClkMuxSt    = 6'b011100,
        TransProgSt = 6'b100111,
        PostTransSt = 6'b010011,
        EscalateSt  = 6'b101100,
        InvalidSt   = 6'b111111
    } fsm_state_e;

    // Token comparison sequencer encoding. Every pair of codes differs in
    // at least three bits, so a single or double upset never lands in
    // another legal state. All-zero is Error so a stuck-at-0 register
    // fails safe.
    typedef enum logic [4:0] {
        TokIdleSt    = 5'b00111,
        TokCompareSt = 5'b11001,
        TokDoneSt    = 5'b11110,
        TokErrorSt   = 5'b00000
    } token_cmp_state_e;

    // The only legal way to turn a plain bit into an lc_tx_t.
    function automatic lc_tx_t lc_tx_bool_to_lc_tx(logic val);
        return val ? On : Off;
    endfunction

    // Number of ChunkWidth slices needed to cover a TokenWidth operand.
    function automatic int lc_token_num_chunks(int token_width, int chunk_width);
        return (token_width + chunk_width - 1) / chunk_width;
    endfunction

endpackage

// File: rtl/lc_token_chunk_cmp.sv
// Combinational chunk selector and comparator: zero-pads both operands to a
// whole number of chunks, picks chunk chunk_idx_i (LSB first) from each and
// reports equality. An out-of-range index compares two zero chunks.
module lc_token_chunk_cmp
    import lc_ctrl_pkg::*;
#(
    parameter  int TokenWidth = 128,
    parameter  int ChunkWidth = 32,
    localparam int NumChunks  = lc_token_num_chunks(TokenWidth, ChunkWidth),
    localparam int CntW       = $clog2(NumChunks + 1)
) (
    input  logic [TokenWidth-1:0] a_i,
    input  logic [TokenWidth-1:0] b_i,
    input  logic [CntW-1:0]       chunk_idx_i,
    output logic                  eq_o
);

    localparam int PadW = NumChunks * ChunkWidth;

    logic [PadW-1:0]       a_pad;
    logic [PadW-1:0]       b_pad;
    logic [ChunkWidth-1:0] a_chunk;
    logic [ChunkWidth-1:0] b_chunk;

    assign a_pad = PadW'(a_i);
    assign b_pad = PadW'(b_i);

    // Select the addressed chunk of both padded operands.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NumChunks; i++) begin
            if (int'(chunk_idx_i) == i) begin
                a_chunk = a_pad[i*ChunkWidth +: ChunkWidth];
                b_chunk = b_pad[i*ChunkWidth +: ChunkWidth];
            end
        end
    end

    assign eq_o = (a_chunk == b_chunk);

endmodule

// File: rtl/lc_token_cmp_seq.sv
// Constant-time sequential token comparator. On accept it latches the user
// hash and the selected hashed constant, then compares them chunk by chunk
// for NumChecks full passes, never terminating early. The result is only
// On if every pass matched, the index was in range and the constant was
// not all-zero. Any illegal state or counter value traps in Error.
module lc_token_cmp_seq
    import lc_ctrl_pkg::*;
#(
    parameter int NumTokens  = 6,
    parameter int TokenWidth = 128,
    parameter int ChunkWidth = 32,
    parameter int NumChecks  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    input  logic [$clog2(NumTokens)-1:0]  token_idx_i,
    input  logic [TokenWidth-1:0]         hashed_token_i,
    input  logic [NumTokens*TokenWidth-1:0] token_mux_i,
    output logic                          ack_o,
    output lc_tx_t                        match_o,
    output logic                          busy_o,
    output logic                          fsm_err_o
);

    localparam int NumChunks = lc_token_num_chunks(TokenWidth, ChunkWidth);
    localparam int CntW      = $clog2(NumChunks + 1);
    localparam int PassW     = $clog2(NumChecks + 1);

    if (ChunkWidth < 1 || ChunkWidth > TokenWidth) begin : gen_bad_chunk_width
        $error("ChunkWidth must lie in 1..TokenWidth");
    end
    if (NumChecks < 1 || NumChecks > 4) begin : gen_bad_num_checks
        $error("NumChecks must lie in 1..4");
    end
    if (NumTokens < 2) begin : gen_bad_num_tokens
        $error("NumTokens must be at least 2");
    end

    token_cmp_state_e      state_q, state_d;
    logic [CntW-1:0]       chunk_q, chunk_d;
    logic [PassW-1:0]      pass_q, pass_d;
    logic                  pass_match_q, pass_match_d;
    logic                  all_match_q, all_match_d;
    logic                  match_q, match_d;
    logic                  ack_q, ack_d;
    logic [TokenWidth-1:0] hash_q, hash_d;
    logic [TokenWidth-1:0] const_q, const_d;

    logic [TokenWidth-1:0] sel_const;
    logic                  idx_ok;
    logic                  chunk_eq;
    logic                  cnt_bad;
    logic                  err;

    // Resolve the selected constant from the mux; out-of-range reads zero.
    always_comb begin
        sel_const = '0;
        for (int i = 0; i < NumTokens; i++) begin
            if (int'(token_idx_i) == i) begin
                sel_const = token_mux_i[i*TokenWidth +: TokenWidth];
            end
        end
    end

    assign idx_ok  = int'(token_idx_i) < NumTokens;
    assign cnt_bad = (int'(chunk_q) >= NumChunks) || (int'(pass_q) >= NumChecks);

    lc_token_chunk_cmp #(
        .TokenWidth (TokenWidth),
        .ChunkWidth (ChunkWidth)
    ) u_chunk_cmp (
        .a_i         (hash_q),
        .b_i         (const_q),
        .chunk_idx_i (chunk_q),
        .eq_o        (chunk_eq)
    );

    // Next-state, counter and flag logic of the compare sequencer.
    always_comb begin
        state_d      = state_q;
        chunk_d      = chunk_q;
        pass_d       = pass_q;
        pass_match_d = pass_match_q;
        all_match_d  = all_match_q;
        match_d      = match_q;
        ack_d        = 1'b0;
        hash_d       = hash_q;
        const_d      = const_q;

        unique case (state_q)
            TokIdleSt: begin
                if (req_i) begin
                    hash_d       = hashed_token_i;
                    const_d      = sel_const;
                    chunk_d      = '0;
                    pass_d       = '0;
                    pass_match_d = 1'b1;
                    // A bad index or an all-zero constant can never match.
                    all_match_d  = idx_ok && (|sel_const);
                    match_d      = 1'b0;
                    state_d      = TokCompareSt;
                end
            end
            TokCompareSt: begin
                pass_match_d = pass_match_q & chunk_eq;
                if (int'(chunk_q) == NumChunks - 1) begin
                    chunk_d      = '0;
                    all_match_d  = all_match_q & pass_match_q & chunk_eq;
                    pass_match_d = 1'b1;
                    if (int'(pass_q) == NumChecks - 1) begin
                        pass_d  = '0;
                        state_d = TokDoneSt;
                    end else begin
                        pass_d = pass_q + PassW'(1);
                    end
                end else begin
                    chunk_d = chunk_q + CntW'(1);
                end
            end
            TokDoneSt: begin
                ack_d   = 1'b1;
                match_d = all_match_q;
                state_d = TokIdleSt;
            end
            TokErrorSt: begin
                match_d = 1'b0;
            end
            default: begin
                state_d = TokErrorSt;
            end
        endcase

        if (cnt_bad) begin
            state_d = TokErrorSt;
            ack_d   = 1'b0;
            match_d = 1'b0;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= TokIdleSt;
            chunk_q      <= '0;
            pass_q       <= '0;
            pass_match_q <= 1'b0;
            all_match_q  <= 1'b0;
            match_q      <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            chunk_q      <= chunk_d;
            pass_q       <= pass_d;
            pass_match_q <= pass_match_d;
            all_match_q  <= all_match_d;
            match_q      <= match_d;
            ack_q        <= ack_d;
        end
    end

    // Latched operands; only loaded on accept, so they need no reset.
    always_ff @(posedge clk_i) begin
        hash_q  <= hash_d;
        const_q <= const_d;
    end

    assign err       = (state_q == TokErrorSt);
    assign fsm_err_o = err;
    assign ack_o     = ack_q & ~err;
    assign busy_o    = (state_q != TokIdleSt) | ack_q;
    assign match_o   = lc_tx_bool_to_lc_tx(match_q & ~err);

endmodule
